pingpong_frame_buffer: RTL

Parametrised, single-clock, double-buffered frame store between the fractal compute engine (writer) and the VGA scan-out (reader). The writer fills the back bank by (x, y) while the reader scans the front bank. A swap request is honoured only at the reader's frame boundary, so the display never tears. An optional clear engine then fills the new back bank with a background value.

---
 rtl/fb_pkg.sv | 38 +++
 rtl/pingpong_frame_buffer_if.sv | 40 ++++
 rtl/fb_ram.sv | 33 +++
 rtl/pingpong_frame_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong frame buffer: FSM encoding,
// default geometry and the ceiling-log2 helper used for port widths.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLEAR   = 2'd2
  } fb_state_e;

  // Ceiling log2, never narrower than one bit so a vector is always legal.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    if (res == 0) begin
      res = 1;
    end else begin
      res = res;
    end
    return res;
  endfunction

  // Geometry for the default 640x480 display.
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int PIXELS    = H_RES_DEF * V_RES_DEF;
  localparam int ADDR_W    = clog2(2 * PIXELS);
  localparam int XW        = clog2(H_RES_DEF);
  localparam int YW        = clog2(V_RES_DEF);

endpackage

// File: rtl/pingpong_frame_buffer_if.sv
// Writer / reader / swap-control bundle of the ping-pong frame buffer.
// master = compute engine plus scan-out side, slave = the frame buffer.
interface pingpong_frame_buffer_if #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DATA_W = 3
);
  import fb_pkg::*;

  localparam int IF_XW = clog2(H_RES);
  localparam int IF_YW = clog2(V_RES);

  logic              wr_en;
  logic [IF_XW-1:0]  wr_x;
  logic [IF_YW-1:0]  wr_y;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_drop;
  logic              rd_en;
  logic [IF_XW-1:0]  rd_x;
  logic [IF_YW-1:0]  rd_y;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_start;
  logic              swap_req;
  logic              swap_pending;
  logic              swap_ack;
  logic              front_sel;

  modport master (
    output wr_en, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y, frame_start, swap_req,
    input  wr_ready, wr_drop, rd_data, rd_valid, swap_pending, swap_ack, front_sel
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y, frame_start, swap_req,
    output wr_ready, wr_drop, rd_data, rd_valid, swap_pending, swap_ack, front_sel
  );

endinterface

// File: rtl/fb_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read
// port. A same-edge read of the word being written returns the old data.
module fb_ram #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: register the addressed word, hold it while idle.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store. The writer fills the back bank while the
// reader scans the front bank; a requested swap is taken only at the
// reader's frame boundary, optionally followed by a back-bank clear.
module pingpong_frame_buffer
  import fb_pkg::*;
#(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int DATA_W        = 3,
  parameter int CLEAR_ON_SWAP = 1,
  parameter int CLEAR_VAL     = 0
) (
  input logic                   clock,
  input logic                   reset_n,
  pingpong_frame_buffer_if.slave bus
);

  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int FB_ADDR_W = clog2(2 * FB_PIXELS);
  localparam int FB_XW     = clog2(H_RES);
  localparam int FB_YW     = clog2(V_RES);
  localparam int CNT_W     = clog2(FB_PIXELS);

  fb_state_e             state_q, state_d;
  logic                  front_q, front_d;
  logic [CNT_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                  pending_q;
  logic                  ack_q;
  logic                  ready_q;
  logic                  drop_q;
  logic                  rd_valid_q;
  logic                  rd_zero_q;
  logic                  swap_fire_s;
  logic                  wr_in_range_s;
  logic                  wr_accept_s;
  logic                  rd_in_range_s;
  logic [FB_ADDR_W-1:0]  wr_addr_s;
  logic [FB_ADDR_W-1:0]  rd_addr_s;
  logic [FB_ADDR_W-1:0]  clr_addr_s;
  logic [FB_ADDR_W-1:0]  ram_waddr_s;
  logic                  ram_we_s;
  logic [DATA_W-1:0]     ram_wdata_s;
  logic [DATA_W-1:0]     ram_rdata_s;

  // Linear word address: bank * PIXELS + y * H_RES + x.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(
    input logic             bank,
    input logic [FB_YW-1:0] y,
    input logic [FB_XW-1:0] x
  );
    logic [FB_ADDR_W-1:0] base;
    if (bank) begin
      base = FB_ADDR_W'(FB_PIXELS);
    end else begin
      base = {FB_ADDR_W{1'b0}};
    end
    return base + FB_ADDR_W'(y) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(x);
  endfunction

  assign wr_in_range_s = (int'(bus.wr_x) < H_RES) && (int'(bus.wr_y) < V_RES);
  assign rd_in_range_s = (int'(bus.rd_x) < H_RES) && (int'(bus.rd_y) < V_RES);
  assign wr_accept_s   = bus.wr_en && ready_q && wr_in_range_s;

  // Writes target the back bank, reads the front bank, clear the back bank.
  assign wr_addr_s  = pix_addr(~front_q, bus.wr_y, bus.wr_x);
  assign rd_addr_s  = pix_addr(front_q, bus.rd_y, bus.rd_x);
  assign clr_addr_s = (front_q ? {FB_ADDR_W{1'b0}} : FB_ADDR_W'(FB_PIXELS))
                      + FB_ADDR_W'(clr_cnt_q);

  // Swap / clear sequencing: next state, bank select and clear counter.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    clr_cnt_d   = clr_cnt_q;
    swap_fire_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.swap_req) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (bus.frame_start) begin
          swap_fire_s = 1'b1;
          front_d     = ~front_q;
          state_d     = (CLEAR_ON_SWAP != 0) ? ST_CLEAR : ST_IDLE;
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CNT_W'(FB_PIXELS - 1)) begin
          clr_cnt_d = {CNT_W{1'b0}};
          state_d   = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
          state_d   = ST_CLEAR;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control registers and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      front_q   <= 1'b0;
      clr_cnt_q <= {CNT_W{1'b0}};
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      clr_cnt_q <= clr_cnt_d;
      pending_q <= (state_d == ST_PENDING);
      ack_q     <= swap_fire_s;
      ready_q   <= (state_d != ST_CLEAR);
    end
  end

  // Write-drop pulse and read-side flags (valid, forced-zero data).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      drop_q     <= bus.wr_en && !wr_accept_s;
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_zero_q <= !rd_in_range_s;
      end else begin
        rd_zero_q <= rd_zero_q;
      end
    end
  end

  // RAM write port belongs to the clear engine while clearing.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = wr_addr_s;
    ram_wdata_s = bus.wr_data;
    if (state_q == ST_CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_s;
      ram_wdata_s = DATA_W'(CLEAR_VAL);
    end else begin
      ram_we_s    = wr_accept_s;
      ram_waddr_s = wr_addr_s;
      ram_wdata_s = bus.wr_data;
    end
  end

  fb_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (2 * FB_PIXELS),
    .ADDR_W (FB_ADDR_W)
  ) u_ram (
    .clk     (clock),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s),
    .re_i    (bus.rd_en && rd_in_range_s),
    .raddr_i (rd_addr_s),
    .rdata_o (ram_rdata_s)
  );

  assign bus.rd_data      = rd_zero_q ? {DATA_W{1'b0}} : ram_rdata_s;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.wr_ready     = ready_q;
  assign bus.wr_drop      = drop_q;
  assign bus.swap_pending = pending_q;
  assign bus.swap_ack     = ack_q;
  assign bus.front_sel    = front_q;

endmodule
